usb_crc_stream: RTL and testbench

//  Parametrised serial USB CRC generator: CRC5 for tokens, CRC16 for data packets.

---
 rtl/usb_crc_pkg.sv | 15 +
 rtl/crc_lfsr_step.sv | 16 +
 rtl/usb_crc_stream_chk.sv | 12 +
 rtl/usb_crc_stream.sv | 170 +++++++++++++++++
 tb/tb_usb_crc_stream.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the serial USB CRC stream block.
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } crc_state_t;

    localparam logic [4:0]  POLY5     = 5'h05;
    localparam logic [15:0] POLY16    = 16'h8005;
    localparam logic [4:0]  RESIDUE5  = 5'h0C;
    localparam logic [15:0] RESIDUE16 = 16'h800D;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial step of an MSB-first CRC LFSR; POLY excludes the implicit x^W term.
module crc_lfsr_step #(
    parameter int unsigned      CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY  = 5'h05
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic fb_s;

    assign fb_s  = bit_i ^ crc_i[CRC_W-1];
    assign crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb_s ? POLY : '0);

endmodule

// File: rtl/usb_crc_stream_chk.sv
// Protocol checker for usb_crc_stream: flags an encoder start during CRC append.
module usb_crc_stream_chk (
    input logic clk,
    input logic rst_b,
    input logic start,
    input logic hold_up
);

    a_no_start_in_crc: assert property (@(posedge clk) disable iff (!rst_b) hold_up |-> !start)
        else $error("usb_crc_stream: start asserted while CRC is being appended");

endmodule

// File: rtl/usb_crc_stream.sv
// Serial USB CRC5/CRC16 generator between bit-stream encoder and bit stuffer.
// Define CRC_CHECK_EN to add the receive-side residue check (rx_mode, chk_valid, crc_ok).
module usb_crc_stream
    import usb_crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = POLY5,
    parameter logic [CRC_W-1:0] RESIDUE = RESIDUE5
) (
    input  logic clk,
    input  logic rst_b,
    input  logic s_in,
    input  logic start,
    input  logic endr,
    input  logic pause,
`ifdef CRC_CHECK_EN
    input  logic rx_mode,
    output logic chk_valid,
    output logic crc_ok,
`endif
    output logic hold_up,
    output logic s_out,
    output logic start_b,
    output logic endr_b
);

    localparam int unsigned CNT_W = $clog2(CRC_W);

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             start_b_q, start_b_d;
    logic             endr_b_q, endr_b_d;
    logic [CRC_W-1:0] crc_base_s;
    logic [CRC_W-1:0] crc_step_s;
    logic             rx_now_s;

`ifdef CRC_CHECK_EN
    logic rx_q, rx_d;
    logic chk_valid_q, chk_valid_d;
    logic crc_ok_q, crc_ok_d;

    // rx_mode is only meaningful alongside start; mid-packet the latched mode applies.
    assign rx_now_s  = start ? rx_mode : rx_q;
    assign chk_valid = chk_valid_q;
    assign crc_ok    = crc_ok_q;
`else
    logic unused_residue_s;

    assign rx_now_s         = 1'b0;
    assign unused_residue_s = ^RESIDUE;
`endif

    // A start bit re-seeds the LFSR, discarding any CRC in progress.
    assign crc_base_s = start ? '1 : crc_q;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_i (crc_base_s),
        .bit_i (s_in),
        .crc_o (crc_step_s)
    );

    assign hold_up = (state_q == CRC);
    assign s_out   = s_out_q;
    assign start_b = start_b_q;
    assign endr_b  = endr_b_q;

    // Next-state and registered-output logic; pause freezes everything.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        start_b_d = start_b_q;
        endr_b_d  = endr_b_q;
`ifdef CRC_CHECK_EN
        rx_d        = rx_q;
        chk_valid_d = chk_valid_q;
        crc_ok_d    = crc_ok_q;
`endif
        if (!pause) begin
            s_out_d   = 1'b0;
            start_b_d = 1'b0;
            endr_b_d  = 1'b0;
`ifdef CRC_CHECK_EN
            chk_valid_d = 1'b0;
`endif
            case (state_q)
                IDLE, DATA: begin
                    if (start || (state_q == DATA)) begin
                        crc_d     = crc_step_s;
                        s_out_d   = s_in;
                        start_b_d = start;
                        state_d   = DATA;
`ifdef CRC_CHECK_EN
                        rx_d = rx_now_s;
`endif
                        if (endr) begin
                            if (rx_now_s) begin
                                state_d  = IDLE;
                                endr_b_d = 1'b1;
`ifdef CRC_CHECK_EN
                                chk_valid_d = 1'b1;
                                crc_ok_d    = (crc_step_s == RESIDUE);
`endif
                            end else begin
                                state_d = CRC;
                                cnt_d   = CNT_W'(CRC_W - 1);
                            end
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CRC: begin
                    // Emit the complemented CRC MSB-first while shifting it out.
                    s_out_d  = ~crc_q[CRC_W-1];
                    crc_d    = {crc_q[CRC_W-2:0], 1'b0};
                    endr_b_d = (cnt_q == '0);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            crc_q     <= '1;
            cnt_q     <= '0;
            s_out_q   <= 1'b0;
            start_b_q <= 1'b0;
            endr_b_q  <= 1'b0;
`ifdef CRC_CHECK_EN
            rx_q        <= 1'b0;
            chk_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            start_b_q <= start_b_d;
            endr_b_q  <= endr_b_d;
`ifdef CRC_CHECK_EN
            rx_q        <= rx_d;
            chk_valid_q <= chk_valid_d;
            crc_ok_q    <= crc_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_crc_stream.sv
// Randomised self-checking bench for usb_crc_stream: a CRC5 and a CRC16 instance
// checked every cycle against a packet-level reference model.
module tb_usb_crc_stream;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] s_in_r  = '0;
    logic [1:0] start_r = '0;
    logic [1:0] endr_r  = '0;
    logic [1:0] pause_r = '0;
    logic [1:0] rx_r    = '0;
    wire  [1:0] s_out_w, start_b_w, endr_b_w, hold_w;
`ifdef CRC_CHECK_EN
    wire  [1:0] cv_w, ok_w;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    usb_crc_stream #(.CRC_W(5), .POLY(5'h05), .RESIDUE(5'h0C)) u_dut5 (
        .clk(clk), .rst_b(rst_b), .s_in(s_in_r[0]), .start(start_r[0]), .endr(endr_r[0]),
        .pause(pause_r[0]),
`ifdef CRC_CHECK_EN
        .rx_mode(rx_r[0]), .chk_valid(cv_w[0]), .crc_ok(ok_w[0]),
`endif
        .hold_up(hold_w[0]), .s_out(s_out_w[0]), .start_b(start_b_w[0]), .endr_b(endr_b_w[0])
    );

    usb_crc_stream #(.CRC_W(16), .POLY(16'h8005), .RESIDUE(16'h800D)) u_dut16 (
        .clk(clk), .rst_b(rst_b), .s_in(s_in_r[1]), .start(start_r[1]), .endr(endr_r[1]),
        .pause(pause_r[1]),
`ifdef CRC_CHECK_EN
        .rx_mode(rx_r[1]), .chk_valid(cv_w[1]), .crc_ok(ok_w[1]),
`endif
        .hold_up(hold_w[1]), .s_out(s_out_w[1]), .start_b(start_b_w[1]), .endr_b(endr_b_w[1])
    );

    usb_crc_stream_chk u_chk5  (.clk(clk), .rst_b(rst_b), .start(start_r[0]), .hold_up(hold_w[0]));
    usb_crc_stream_chk u_chk16 (.clk(clk), .rst_b(rst_b), .start(start_r[1]), .hold_up(hold_w[1]));

    // ---------------- reference model (packet level) ----------------
    bit          txb [0:1023];
    bit          mbits [2][0:1023];
    int          nb [2];
    bit          inpkt [2];
    bit          rxp [2];
    logic [15:0] pcrc [2];
    int          pend [2];
    int          seq [2];
    bit          exp_s [2], exp_sb [2], exp_eb [2], exp_hold [2], exp_cv [2], exp_ok [2];

    bit          cap [2][0:1023];
    int          clen [2];
    int          seen [2];
    bit          last_ok [2];

    function automatic int wid(input int u);
        return (u == 0) ? 5 : 16;
    endfunction

    function automatic logic [15:0] polyv(input int u);
        return (u == 0) ? 16'h0005 : 16'h8005;
    endfunction

    function automatic logic [15:0] resv(input int u);
        return (u == 0) ? 16'h000C : 16'h800D;
    endfunction

    // CRC register after shifting n message bits through an all-ones-seeded LFSR.
    function automatic logic [15:0] crc_calc(input int w, input logic [15:0] p,
                                             input bit b [0:1023], input int n);
        logic [15:0] m;
        logic [15:0] c;
        bit          fb;
        m = (16'h0001 << w) - 16'h0001;
        c = m;
        for (int i = 0; i < n; i++) begin
            fb = b[i] ^ c[w-1];
            c  = ((c << 1) & m) ^ (fb ? p : 16'h0000);
        end
        return c;
    endfunction

    task automatic model_step();
        logic [15:0] c;
        for (int u = 0; u < 2; u++) begin
            if (!rst_b) begin
                nb[u] = 0; inpkt[u] = 1'b0; rxp[u] = 1'b0; pend[u] = 0;
                exp_s[u] = 1'b0; exp_sb[u] = 1'b0; exp_eb[u] = 1'b0;
                exp_hold[u] = 1'b0; exp_cv[u] = 1'b0; exp_ok[u] = 1'b0;
            end else if (!pause_r[u]) begin
                exp_s[u] = 1'b0; exp_sb[u] = 1'b0; exp_eb[u] = 1'b0; exp_cv[u] = 1'b0;
                if (pend[u] > 0) begin
                    exp_s[u]  = ~pcrc[u][pend[u]-1];
                    exp_eb[u] = (pend[u] == 1);
                    pend[u]--;
                    seq[u]++;
                end else if (start_r[u] || inpkt[u]) begin
                    if (start_r[u]) begin
                        nb[u]  = 0;
                        rxp[u] = rx_r[u];
                    end
                    mbits[u][nb[u]] = s_in_r[u];
                    nb[u]++;
                    exp_s[u]  = s_in_r[u];
                    exp_sb[u] = start_r[u];
                    inpkt[u]  = 1'b1;
                    seq[u]++;
                    if (endr_r[u]) begin
                        inpkt[u] = 1'b0;
                        c = crc_calc(wid(u), polyv(u), mbits[u], nb[u]);
                        if (rxp[u]) begin
                            exp_eb[u] = 1'b1;
                            exp_cv[u] = 1'b1;
                            exp_ok[u] = (c == resv(u));
                        end else begin
                            pcrc[u] = c;
                            pend[u] = wid(u);
                        end
                    end
                end
                exp_hold[u] = (pend[u] > 0);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_b);
        model_step();
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Per-cycle comparison against the model, plus capture of each emitted stream.
    initial forever begin
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d s_out", u),   64'(s_out_w[u]),   64'(exp_s[u]));
            check($sformatf("u%0d start_b", u), 64'(start_b_w[u]), 64'(exp_sb[u]));
            check($sformatf("u%0d endr_b", u),  64'(endr_b_w[u]),  64'(exp_eb[u]));
            check($sformatf("u%0d hold_up", u), 64'(hold_w[u]),    64'(exp_hold[u]));
`ifdef CRC_CHECK_EN
            check($sformatf("u%0d chk_valid", u), 64'(cv_w[u]), 64'(exp_cv[u]));
            if (exp_cv[u]) check($sformatf("u%0d crc_ok", u), 64'(ok_w[u]), 64'(exp_ok[u]));
`endif
            if (seq[u] != seen[u]) begin
                seen[u] = seq[u];
                if (exp_sb[u]) clen[u] = 0;
                if (clen[u] < 1024) begin
                    cap[u][clen[u]] = s_out_w[u];
                    clen[u]++;
                end
`ifdef CRC_CHECK_EN
                if (exp_cv[u]) last_ok[u] = ok_w[u];
`endif
            end
        end
    end

    function automatic logic [63:0] pack(input int u, input int n);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < n; i++) v = {v[62:0], cap[u][i]};
        return v;
    endfunction

    // pm: 0 no pause, 1 random pause, 2 three-cycle pause mid-payload and mid-CRC.
    task automatic send(input int u, input int n, input bit rx, input int pm, input bit abort);
        int pc;
        int k;
        pc = 0;
        for (int i = 0; i < n; i++) begin
            forever begin
                @(negedge clk);
                s_in_r[u] = txb[i]; start_r[u] = (i == 0); endr_r[u] = (i == n - 1); rx_r[u] = rx;
                pause_r[u] = (pm == 1) ? ($urandom_range(0, 3) == 0) : (pm == 2 && i == n / 2 && pc < 3);
                if (pause_r[u]) pc++;
                @(posedge clk);
                if (!pause_r[u]) break;
            end
        end
        pc = 0;
        k  = 0;
        forever begin
            @(negedge clk);
            s_in_r[u] = 1'b0; start_r[u] = 1'b0; endr_r[u] = 1'b0; pause_r[u] = 1'b0; rx_r[u] = 1'b0;
            if (pend[u] == 0) break;
            if (abort && k == 2) begin
                #2 rst_b = 1'b0;
                #1;
                check("abort s_out",   64'(s_out_w[u]),   64'h0);
                check("abort start_b", 64'(start_b_w[u]), 64'h0);
                check("abort endr_b",  64'(endr_b_w[u]),  64'h0);
                check("abort hold_up", 64'(hold_w[u]),    64'h0);
                @(negedge clk);
                rst_b = 1'b1;
                break;
            end
            if (k > 100) begin
                check("crc drain", 64'(pend[u]), 64'h0);
                break;
            end
            pause_r[u] = (pm == 1) ? ($urandom_range(0, 3) == 0) : (pm == 2 && pend[u] == wid(u) - 2 && pc < 3);
            if (pause_r[u]) pc++;
            k++;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ref_v;
        int          n;
        repeat (3) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset u%0d s_out", u),   64'(s_out_w[u]),   64'h0);
            check($sformatf("reset u%0d start_b", u), 64'(start_b_w[u]), 64'h0);
            check($sformatf("reset u%0d endr_b", u),  64'(endr_b_w[u]),  64'h0);
            check($sformatf("reset u%0d hold_up", u), 64'(hold_w[u]),    64'h0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // SETUP addr0/ep0 token: 11 zeros, CRC5 bits 0,1,0,0,0
        for (int i = 0; i < 11; i++) txb[i] = 1'b0;
        check("t1 model crc5", crc_calc(5, 16'h0005, txb, 11), 64'h17);
        send(0, 11, 1'b0, 0, 1'b0);
        check("t1 length", 64'(clen[0]), 64'd16);
        check("t1 stream", pack(0, 16), 64'h0008);

        // single-bit payload '1' with start and endr together
        txb[0] = 1'b1;
        send(0, 1, 1'b0, 0, 1'b0);
        check("t5 length", 64'(clen[0]), 64'd6);
        check("t5 stream", pack(0, 6), 64'h21);

        // pause mid-payload and mid-CRC must not alter the stream
        for (int i = 0; i < 20; i++) txb[i] = 1'($urandom_range(0, 1));
        send(0, 20, 1'b0, 0, 1'b0);
        ref_v = pack(0, 25);
        send(0, 20, 1'b0, 2, 1'b0);
        check("t4 length", 64'(clen[0]), 64'd25);
        check("t4 paused stream", pack(0, 25), ref_v);

`ifdef CRC_CHECK_EN
        for (int i = 0; i < 16; i++) txb[i] = (i == 12);
        send(0, 16, 1'b1, 0, 1'b0);
        check("t2 rx length", 64'(clen[0]), 64'd16);
        check("t2 crc_ok good", 64'(last_ok[0]), 64'h1);
        txb[5] = 1'b1;
        send(0, 16, 1'b1, 0, 1'b0);
        check("t2 crc_ok flipped", 64'(last_ok[0]), 64'h0);
`endif

        // random CRC5 tokens with random pause
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) txb[i] = 1'($urandom_range(0, 1));
            send(0, n, 1'b0, 1, 1'b0);
            check("crc5 rand length", 64'(clen[0]), 64'(n + 5));
        end

        // CRC16 data packets of 1..64 bytes, looped back through the checker
        for (int p = 0; p < 6; p++) begin
            n = 8 * ((p == 0) ? 1 : (p == 1) ? 64 : $urandom_range(1, 64));
            for (int i = 0; i < n; i++) txb[i] = 1'($urandom_range(0, 1));
            send(1, n, 1'b0, 1, 1'b0);
            check("t3 length", 64'(clen[1]), 64'(n + 16));
            for (int i = 0; i < clen[1]; i++) txb[i] = cap[1][i];
            check("t3 residue", crc_calc(16, 16'h8005, txb, n + 16), 64'h800D);
`ifdef CRC_CHECK_EN
            send(1, n + 16, 1'b1, 1, 1'b0);
            check("t3 loopback crc_ok", 64'(last_ok[1]), 64'h1);
`endif
        end

        // reset during CRC append, then a clean packet
        for (int i = 0; i < 11; i++) txb[i] = 1'($urandom_range(0, 1));
        send(0, 11, 1'b0, 0, 1'b1);
        for (int i = 0; i < 11; i++) txb[i] = 1'($urandom_range(0, 1));
        send(0, 11, 1'b0, 0, 1'b0);
        check("t6 length", 64'(clen[0]), 64'd16);
        for (int i = 0; i < 16; i++) txb[i] = cap[0][i];
        check("t6 residue", crc_calc(5, 16'h0005, txb, 16), 64'h0C);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
